// File: rtl/match_controller_pkg.sv
// Shared phase encoding, player ids and score helpers for the match controller.
// Imported by the controller, its interface and its bench.
package match_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        PAUSE = 3'd3,
        OVER  = 3'd4
    } phase_t;

    localparam logic [6:0] SCORE_MAX = 7'd99;
    localparam logic       PLAYER_A  = 1'b0;
    localparam logic       PLAYER_B  = 1'b1;

    // Scores stick at SCORE_MAX so they never run ahead of the display counters.
    function automatic logic [6:0] sat_inc(input logic [6:0] s);
        return (s >= SCORE_MAX) ? SCORE_MAX : s + 7'd1;
    endfunction

endpackage

// File: rtl/match_controller_if.sv
// Field/score-counter side bundle of the match controller.
// slave = controller view, master = driver of the sensors/start button.
interface match_controller_if;
    import match_pkg::*;

    logic   start;
    logic   goal_a;
    logic   goal_b;
    logic   goal_inc_a;
    logic   goal_inc_b;
    logic   dis_score;
    logic   ball_en;
    logic   serve_dir;
    phase_t phase;
    logic   game_over;
    logic   winner;

    modport master (
        output start, goal_a, goal_b,
        input  goal_inc_a, goal_inc_b, dis_score, ball_en, serve_dir,
               phase, game_over, winner
    );

    modport slave (
        input  start, goal_a, goal_b,
        output goal_inc_a, goal_inc_b, dis_score, ball_en, serve_dir,
               phase, game_over, winner
    );

endinterface

// File: rtl/match_controller_pause_timer.sv
// Purpose: loadable down-counter timing the post-goal pause; done while count is zero.
// Latency: load takes effect next cycle; done is a decode of the count register.
// Backpressure: none; counts only while en is high and holds at zero.
module pause_timer #(
    parameter int CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam int             W        = $clog2(CYCLES);
    localparam logic [W-1:0]   LOAD_VAL = W'(CYCLES - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = LOAD_VAL;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/match_controller.sv
// Purpose: two-player match sequencer: goal edge detect, tie arbitration, scores, phases.
// Latency: goal edge sampled at edge N -> goal_inc pulse and new phase visible at N+1.
// Backpressure: none; start outside IDLE/SERVE/OVER and goal edges outside PLAY are dropped.
module match_controller
    import match_pkg::*;
#(
    parameter int WIN_SCORE    = 7,
    parameter int PAUSE_CYCLES = 100_000_000
) (
    input  logic               clk,
    input  logic               rst,
    match_controller_if.slave  bus
);

    phase_t     state_q, state_d;
    logic       goal_a_q, goal_b_q;
    logic       last_q, last_d;
    logic [6:0] score_a_q, score_a_d;
    logic [6:0] score_b_q, score_b_d;
    logic       serve_dir_q, serve_dir_d;
    logic       winner_q, winner_d;
    logic       goal_inc_a_q, goal_inc_a_d;
    logic       goal_inc_b_q, goal_inc_b_d;
    logic       dis_score_q, dis_score_d;
    logic       ball_en_q, ball_en_d;
    logic       game_over_q, game_over_d;

    logic       edge_a, edge_b;
    logic       credit_a, credit_b;
    logic [6:0] new_score;
    logic       timer_load, timer_en, timer_done;

    pause_timer #(
        .CYCLES (PAUSE_CYCLES)
    ) u_pause_timer (
        .clk  (clk),
        .rst  (rst),
        .load (timer_load),
        .en   (timer_en),
        .done (timer_done)
    );

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        score_a_d    = score_a_q;
        score_b_d    = score_b_q;
        serve_dir_d  = serve_dir_q;
        winner_d     = winner_q;
        goal_inc_a_d = 1'b0;
        goal_inc_b_d = 1'b0;
        timer_load   = 1'b0;
        timer_en     = 1'b0;

        edge_a    = bus.goal_a & ~goal_a_q;
        edge_b    = bus.goal_b & ~goal_b_q;
        // On a tie the player not credited last takes the goal.
        credit_b  = edge_b & (~edge_a | (last_q == PLAYER_A));
        credit_a  = edge_a & ~credit_b;
        new_score = credit_b ? sat_inc(score_b_q) : sat_inc(score_a_q);

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = SERVE;
                    score_a_d   = '0;
                    score_b_d   = '0;
                    serve_dir_d = PLAYER_A;
                end
            end
            SERVE: begin
                if (bus.start) state_d = PLAY;
            end
            PLAY: begin
                if (credit_a || credit_b) begin
                    goal_inc_a_d = credit_a;
                    goal_inc_b_d = credit_b;
                    if (credit_b) score_b_d = new_score;
                    else          score_a_d = new_score;
                    last_d      = credit_b;
                    serve_dir_d = ~credit_b;
                    if (new_score == 7'(WIN_SCORE)) begin
                        state_d  = OVER;
                        winner_d = credit_b;
                    end else begin
                        state_d    = PAUSE;
                        timer_load = 1'b1;
                    end
                end
            end
            PAUSE: begin
                timer_en = 1'b1;
                if (timer_done) state_d = SERVE;
            end
            OVER: begin
                if (bus.start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered off the next state so they line up with phase.
        dis_score_d = (state_d != IDLE);
        ball_en_d   = (state_d == PLAY);
        game_over_d = (state_d == OVER);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            goal_a_q     <= 1'b0;
            goal_b_q     <= 1'b0;
            last_q       <= PLAYER_B;
            score_a_q    <= '0;
            score_b_q    <= '0;
            serve_dir_q  <= 1'b0;
            winner_q     <= 1'b0;
            goal_inc_a_q <= 1'b0;
            goal_inc_b_q <= 1'b0;
            dis_score_q  <= 1'b0;
            ball_en_q    <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            goal_a_q     <= bus.goal_a;
            goal_b_q     <= bus.goal_b;
            last_q       <= last_d;
            score_a_q    <= score_a_d;
            score_b_q    <= score_b_d;
            serve_dir_q  <= serve_dir_d;
            winner_q     <= winner_d;
            goal_inc_a_q <= goal_inc_a_d;
            goal_inc_b_q <= goal_inc_b_d;
            dis_score_q  <= dis_score_d;
            ball_en_q    <= ball_en_d;
            game_over_q  <= game_over_d;
        end
    end

    assign bus.phase      = state_q;
    assign bus.goal_inc_a = goal_inc_a_q;
    assign bus.goal_inc_b = goal_inc_b_q;
    assign bus.dis_score  = dis_score_q;
    assign bus.ball_en    = ball_en_q;
    assign bus.serve_dir  = serve_dir_q;
    assign bus.game_over  = game_over_q;
    assign bus.winner     = winner_q;

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: directed match scenarios followed by random sensor/start
// traffic, every cycle compared against a rule-level model of the match.
module tb_match_controller;
    import match_pkg::*;

    localparam int WIN = 3;
    localparam int PC  = 4;

    logic clk;
    logic rst;
    match_controller_if bus();

    match_controller #(
        .WIN_SCORE    (WIN),
        .PAUSE_CYCLES (PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_a   = 0;
    int cnt_b   = 0;

    // Reference model of the match, advanced once per clock.
    phase_t m_phase   = IDLE;
    logic   m_prev_a  = 1'b0;
    logic   m_prev_b  = 1'b0;
    logic   m_last    = 1'b1;
    int     m_score[2] = '{0, 0};
    logic   m_serve   = 1'b0;
    logic   m_winner  = 1'b0;
    int     m_left    = 0;
    logic   m_inc_a   = 1'b0;
    logic   m_inc_b   = 1'b0;

    logic ga = 1'b0;
    logic gb = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic s, input logic a, input logic b);
        logic ra, rb, who;
        m_inc_a = 1'b0;
        m_inc_b = 1'b0;
        if (r) begin
            m_phase  = IDLE;
            m_prev_a = 1'b0;
            m_prev_b = 1'b0;
            m_last   = 1'b1;
            m_score  = '{0, 0};
            m_serve  = 1'b0;
            m_winner = 1'b0;
            m_left   = 0;
            return;
        end
        ra = a && !m_prev_a;
        rb = b && !m_prev_b;
        case (m_phase)
            IDLE:  if (s) begin m_phase = SERVE; m_score = '{0, 0}; m_serve = 1'b0; end
            SERVE: if (s) m_phase = PLAY;
            PLAY: begin
                if (ra || rb) begin
                    if (ra && rb) who = !m_last;
                    else          who = rb;
                    if (who) m_inc_b = 1'b1; else m_inc_a = 1'b1;
                    if (m_score[who] < 99) m_score[who] = m_score[who] + 1;
                    m_last  = who;
                    m_serve = !who;
                    if (m_score[who] == WIN) begin
                        m_phase  = OVER;
                        m_winner = who;
                    end else begin
                        m_phase = PAUSE;
                        m_left  = PC;
                    end
                end
            end
            PAUSE: begin
                m_left = m_left - 1;
                if (m_left == 0) m_phase = SERVE;
            end
            OVER: if (s) m_phase = IDLE;
            default: m_phase = IDLE;
        endcase
        m_prev_a = a;
        m_prev_b = b;
    endtask

    // Drive one clock of inputs, advance the model, sample on the following falling edge.
    task automatic cyc(input logic r, input logic s, input logic a, input logic b);
        rst = r;
        bus.start  = s;
        bus.goal_a = a;
        bus.goal_b = b;
        model_step(r, s, a, b);
        @(posedge clk);
        @(negedge clk);
        chk("phase",      32'(bus.phase),      32'(m_phase));
        chk("goal_inc_a", 32'(bus.goal_inc_a), 32'(m_inc_a));
        chk("goal_inc_b", 32'(bus.goal_inc_b), 32'(m_inc_b));
        chk("ball_en",    32'(bus.ball_en),    32'(m_phase == PLAY));
        chk("dis_score",  32'(bus.dis_score),  32'(m_phase != IDLE));
        chk("serve_dir",  32'(bus.serve_dir),  32'(m_serve));
        chk("game_over",  32'(bus.game_over),  32'(m_phase == OVER));
        if (m_phase == OVER) chk("winner", 32'(bus.winner), 32'(m_winner));
        if (bus.goal_inc_a === 1'b1) cnt_a++;
        if (bus.goal_inc_b === 1'b1) cnt_b++;
    endtask

    // From PLAY: one goal edge, sit out the pause, serve again.
    task automatic score(input logic a, input logic b);
        cyc(0, 0, a, b);
        cyc(0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
    endtask

    task automatic new_match();
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cnt_a = 0;
        cnt_b = 0;
    endtask

    initial begin
        rst = 1'b1;
        bus.start  = 1'b0;
        bus.goal_a = 1'b0;
        bus.goal_b = 1'b0;
        @(negedge clk);

        // Reset values.
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("rst_phase",  32'(bus.phase),     32'(IDLE));
        chk("rst_winner", 32'(bus.winner),    32'd0);
        chk("rst_dis",    32'(bus.dis_score), 32'd0);

        // Single goal from a 3-cycle level, full pause, back to SERVE.
        new_match();
        chk("sc1_play", 32'(bus.phase), 32'(PLAY));
        cyc(0, 0, 1, 0);
        chk("sc1_inc_n1", 32'(bus.goal_inc_a), 32'd1);
        cyc(0, 0, 1, 0);
        chk("sc1_inc_n2", 32'(bus.goal_inc_a), 32'd0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        chk("sc1_still_pause", 32'(bus.phase), 32'(PAUSE));
        cyc(0, 0, 0, 0);
        chk("sc1_serve", 32'(bus.phase), 32'(SERVE));
        chk("sc1_dir",   32'(bus.serve_dir), 32'd1);
        chk("sc1_pulses_a", 32'(cnt_a), 32'd1);
        chk("sc1_pulses_b", 32'(cnt_b), 32'd0);

        // Simultaneous edges: A wins the first tie, B the next.
        new_match();
        score(1, 1);
        chk("tie1_a", 32'(cnt_a), 32'd1);
        chk("tie1_b", 32'(cnt_b), 32'd0);
        score(1, 1);
        chk("tie2_a", 32'(cnt_a), 32'd1);
        chk("tie2_b", 32'(cnt_b), 32'd1);

        // B wins 3-0, then start returns to IDLE and clears the counters.
        new_match();
        score(0, 1);
        score(0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        chk("win_over",   32'(bus.game_over), 32'd1);
        chk("win_winner", 32'(bus.winner),    32'd1);
        chk("win_dis",    32'(bus.dis_score), 32'd1);
        chk("win_pulses", 32'(cnt_b),         32'd3);
        cyc(0, 1, 0, 0);
        chk("win_idle",   32'(bus.phase),     32'(IDLE));
        chk("win_clear",  32'(bus.dis_score), 32'd0);

        // goal_b held through PAUSE and SERVE: no second pulse until it re-rises.
        new_match();
        cyc(0, 0, 0, 1);
        repeat (4) cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 1);
        repeat (3) cyc(0, 0, 0, 1);
        chk("held_pulses", 32'(cnt_b), 32'd1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        chk("held_rerise", 32'(cnt_b), 32'd2);

        // Reset in the middle of a pause with the score at 2-1.
        new_match();
        score(1, 0);
        score(0, 1);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("mid_rst_phase", 32'(bus.phase),     32'(IDLE));
        chk("mid_rst_dis",   32'(bus.dis_score), 32'd0);

        // start ignored in PLAY and PAUSE.
        new_match();
        cyc(0, 1, 0, 0);
        chk("start_in_play", 32'(bus.phase), 32'(PLAY));
        cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        chk("start_in_pause", 32'(bus.phase), 32'(PAUSE));
        repeat (4) cyc(0, 0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            logic r, s;
            r = ($urandom_range(0, 399) == 0);
            s = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) ga = ~ga;
            if ($urandom_range(0, 3) == 0) gb = ~gb;
            if ($urandom_range(0, 7) == 0) begin
                ga = ~ga;
                gb = ga;
            end
            cyc(r, s, ga, gb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
